// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// optional parity, 1 or 2 stop bits, and a one-word holding register with overrun pulse.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam logic [15:0] HALF_CNT  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_r;
  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic                 rx_prev_r;
  logic [15:0]          cnt_r;
  logic [3:0]           bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_bad_r;
  logic                 frame_bad_r;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 data_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_err_r;

  // Parity bit the transmitter should have sent for the given word.
  function automatic logic parity_exp(input logic [DATA_BITS-1:0] d);
    if (PARITY_MODE == 2) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  // Synchroniser plus one extra stage for falling-edge detection; resets to line idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_in;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM and output holding register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      bit_idx_r     <= 4'd0;
      stop_idx_r    <= 1'b0;
      shift_r       <= '0;
      parity_bad_r  <= 1'b0;
      frame_bad_r   <= 1'b0;
      data_out_r    <= '0;
      data_valid_r  <= 1'b0;
      parity_err_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      overrun_err_r <= 1'b0;
      if (data_valid_r && data_ready) begin
        data_valid_r <= 1'b0;
      end else begin
        data_valid_r <= data_valid_r;
      end
      case (state_r)
        ST_IDLE: begin
          // Only a genuine high-to-low transition starts a frame, so a held break is ignored.
          if (rx_prev_r && !rx_sync_r) begin
            state_r      <= ST_START;
            cnt_r        <= HALF_CNT;
            bit_idx_r    <= 4'd0;
            stop_idx_r   <= 1'b0;
            parity_bad_r <= 1'b0;
            frame_bad_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else if (rx_sync_r) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DATA;
            cnt_r   <= FULL_CNT;
          end
        end
        ST_DATA: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else begin
            shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
            cnt_r   <= FULL_CNT;
            if (bit_idx_r == LAST_BIT) begin
              bit_idx_r <= 4'd0;
              state_r   <= (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else begin
            parity_bad_r <= rx_sync_r ^ parity_exp(shift_r);
            cnt_r        <= FULL_CNT;
            state_r      <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else if (stop_idx_r != LAST_STOP) begin
            frame_bad_r <= frame_bad_r | ~rx_sync_r;
            stop_idx_r  <= stop_idx_r + 1'b1;
            cnt_r       <= FULL_CNT;
          end else begin
            state_r <= ST_IDLE;
            // A completing frame may replace the held word only if that word leaves this cycle.
            if (!data_valid_r || data_ready) begin
              data_out_r   <= shift_r;
              parity_err_r <= parity_bad_r;
              frame_err_r  <= frame_bad_r | ~rx_sync_r;
              data_valid_r <= 1'b1;
            end else begin
              overrun_err_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_out_r;
  assign data_valid  = data_valid_r;
  assign parity_err  = parity_err_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default-style instance (8E1) and a 7O2 instance,
// with expected words queued at send time and popped on each handshake.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       ready_a = 1'b1;
  logic       ready_b = 1'b1;
  logic [7:0] data_out_a;
  logic [6:0] data_out_b;
  logic       valid_a, valid_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       ovr_a, ovr_b;

  int   checks = 0;
  int   errors = 0;
  int   hi_cnt = 0;
  int   ov_cnt = 0;
  int   base;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clock = ~clock;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .rx_in(rx_a), .data_out(data_out_a),
    .data_valid(valid_a), .data_ready(ready_a), .parity_err(perr_a),
    .frame_err(ferr_a), .overrun_err(ovr_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .rx_in(rx_b), .data_out(data_out_b),
    .data_valid(valid_b), .data_ready(ready_b), .parity_err(perr_b),
    .frame_err(ferr_b), .overrun_err(ovr_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // 8 data bits, even parity, one stop bit.
  task automatic send_a(input logic [7:0] d, input logic par, input logic stop, input bit keep);
    exp_t e;
    if (keep) begin
      e.data = {1'b0, d};
      e.perr = par ^ (^d);
      e.ferr = ~stop;
      q_a.push_back(e);
    end
    rx_a = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      tick(CPB);
    end
    rx_a = par;
    tick(CPB);
    rx_a = stop;
    tick(CPB);
    rx_a = 1'b1;
  endtask

  // 7 data bits, odd parity, two stop bits.
  task automatic send_b(input logic [6:0] d, input logic par, input logic stop1, input logic stop2);
    exp_t e;
    e.data = {2'b00, d};
    e.perr = par ^ ~(^d);
    e.ferr = ~(stop1 & stop2);
    q_b.push_back(e);
    rx_b = 1'b0;
    tick(CPB);
    for (int i = 0; i < 7; i++) begin
      rx_b = d[i];
      tick(CPB);
    end
    rx_b = par;
    tick(CPB);
    rx_b = stop1;
    tick(CPB);
    rx_b = stop2;
    tick(CPB);
    rx_b = 1'b1;
  endtask

  initial begin
    exp_t e;
    fork
      forever begin
        @(negedge clock);
        if (valid_a) hi_cnt++;
        if (ovr_a) ov_cnt++;
        if (reset_n && valid_a && ready_a) begin
          check("queue_a_nonempty", 16'(q_a.size() != 0), 16'd1);
          if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("word_a", 16'({1'b0, data_out_a, perr_a, ferr_a}), 16'(e));
          end
        end
        if (reset_n && valid_b && ready_b) begin
          check("queue_b_nonempty", 16'(q_b.size() != 0), 16'd1);
          if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("word_b", 16'({2'b00, data_out_b, perr_b, ferr_b}), 16'(e));
          end
        end
      end
    join_none

    tick(4);
    check("reset_outs_a", 16'({data_out_a, valid_a, perr_a, ferr_a, ovr_a}), 16'd0);
    check("reset_outs_b", 16'({data_out_b, valid_b, perr_b, ferr_b, ovr_b}), 16'd0);
    reset_n = 1'b1;
    tick(10);

    // Clean frame, valid for exactly one cycle with ready held high.
    base = hi_cnt;
    send_a(8'hA5, 1'b0, 1'b1, 1'b1);
    tick(10);
    check("a5_valid_cycles", 16'(hi_cnt - base), 16'd1);
    check("a5_valid_cleared", 16'(valid_a), 16'd0);

    // Short low glitch is rejected at the start sample.
    base = hi_cnt;
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(60);
    check("glitch_no_valid", 16'(hi_cnt - base), 16'd0);

    // Parity error then framing error, both delivered.
    send_a(8'h3C, 1'b1, 1'b1, 1'b1);
    send_a(8'h81, 1'b0, 1'b0, 1'b1);
    tick(30);

    // Overrun: second frame dropped, then a third frame loads in the handshake cycle.
    ready_a = 1'b0;
    base = ov_cnt;
    send_a(8'h11, 1'b0, 1'b1, 1'b1);
    send_a(8'h22, 1'b0, 1'b1, 1'b0);
    tick(4);
    check("overrun_pulses", 16'(ov_cnt - base), 16'd1);
    check("held_word_11", 16'({data_out_a, valid_a}), 16'({8'h11, 1'b1}));
    base = ov_cnt;
    fork
      send_a(8'h33, 1'b0, 1'b1, 1'b1);
      begin
        tick(170);
        ready_a = 1'b1;
      end
    join
    tick(4);
    check("no_overrun_on_handshake", 16'(ov_cnt - base), 16'd0);
    check("word_33_loaded", 16'(data_out_a), 16'h33);
    tick(10);

    // Reset mid-frame abandons the partial 0xFF.
    rx_a = 1'b0;
    tick(CPB);
    rx_a = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset_n = 1'b0;
    tick(3);
    check("midframe_reset_outs", 16'({data_out_a, valid_a, perr_a, ferr_a, ovr_a}), 16'd0);
    reset_n = 1'b1;
    tick(3 * CPB);
    send_a(8'h5A, 1'b0, 1'b1, 1'b1);
    tick(20);
    check("word_5a_present", 16'(data_out_a), 16'h5A);

    // Break: one framed-error zero word, nothing more until the line recovers.
    base = hi_cnt;
    e.data = 9'h000;
    e.perr = 1'b0;
    e.ferr = 1'b1;
    q_a.push_back(e);
    rx_a = 1'b0;
    tick(400);
    rx_a = 1'b1;
    tick(40);
    check("break_single_word", 16'(hi_cnt - base), 16'd1);

    // 7O2 with the second stop bit low.
    send_b(7'h7F, 1'b0, 1'b1, 1'b0);
    tick(20);
    check("b_word_7f", 16'({data_out_b, perr_b, ferr_b}), 16'({7'h7F, 1'b0, 1'b1}));

    tick(20);
    check("queue_a_drained", 16'(q_a.size()), 16'd0);
    check("queue_b_drained", 16'(q_b.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
